regfile_wb_arbiter: RTL

- Arbitrates the single register-file write port between the in-order pipeline writeback and the out-of-band multi-cycle mul/div unit.
- Mul/div results that lose arbitration wait in a small FIFO.
- A starvation counter forces a one-cycle pipeline stall so queued results always drain.
- Exports a pending-register mask so decode can stall on RAW/WAW against queued results.

---
 rtl/regfile_wb_arbiter_if.sv | 36 +++
 rtl/regfile_wb_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the writeback arbiter and its surroundings: pipeline
// writeback request, mul/div result handshake, regfile write port and the
// hazard/occupancy status seen by decode.
interface regfile_wb_arbiter_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          pipe_valid;
  logic [4:0]    pipe_rd;
  logic [31:0]   pipe_data;
  logic          md_valid;
  logic [4:0]    md_rd;
  logic [31:0]   md_data;
  logic          md_ready;
  logic          pipe_stall;
  logic [31:0]   regfile_in;
  logic [4:0]    dest;
  logic          load_regfile;
  logic [31:0]   pending_mask;
  logic [CW-1:0] fifo_count;

  // Producer side: pipeline / mul-div unit / decode
  modport master (
    output pipe_valid, pipe_rd, pipe_data, md_valid, md_rd, md_data,
    input  md_ready, pipe_stall, regfile_in, dest, load_regfile,
           pending_mask, fifo_count
  );

  // Arbiter side
  modport slave (
    input  pipe_valid, pipe_rd, pipe_data, md_valid, md_rd, md_data,
    output md_ready, pipe_stall, regfile_in, dest, load_regfile,
           pending_mask, fifo_count
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter. The in-order pipeline writeback normally
// owns the port; mul/div results that lose arbitration queue in a small
// in-order FIFO. A starvation counter forces a single-cycle pipeline stall so
// the queue always drains, and a pending-register mask lets decode stall on
// hazards against queued results.
module regfile_wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  // Grant source select
  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_PIPE = 2'd1;
  localparam logic [1:0] SRC_HEAD = 2'd2;
  localparam logic [1:0] SRC_BYP  = 2'd3;

  logic [4:0]    rd_mem_r   [DEPTH];
  logic [31:0]   data_mem_r [DEPTH];
  logic [DEPTH-1:0] valid_r;
  logic [AW-1:0] head_r;
  logic [AW-1:0] tail_r;
  logic [CW-1:0] count_r;
  logic [SW-1:0] starve_r;

  logic          empty_s;
  logic          stall_s;
  logic          ready_s;
  logic          pipe_req_s;
  logic          md_nz_s;
  logic [1:0]    src_s;
  logic          pop_s;
  logic          push_s;
  logic [4:0]    dest_s;
  logic [31:0]   wdata_s;
  logic [31:0]   mask_s;

  // Handshake/status terms derive only from registered state
  assign empty_s    = (count_r == {CW{1'b0}});
  assign stall_s    = (starve_r == SW'(STARVE_LIMIT));
  assign ready_s    = (count_r < CW'(DEPTH));
  assign pipe_req_s = bus.pipe_valid && (bus.pipe_rd != 5'd0) && !stall_s;
  assign md_nz_s    = bus.md_valid && ready_s && (bus.md_rd != 5'd0);

  // Fixed-priority grant; nothing is granted while reset is held
  always_comb begin
    src_s = SRC_NONE;
    if (!rst) begin
      src_s = SRC_NONE;
    end else if (stall_s) begin
      src_s = SRC_HEAD;
    end else if (pipe_req_s) begin
      src_s = SRC_PIPE;
    end else if (!empty_s) begin
      src_s = SRC_HEAD;
    end else if (md_nz_s) begin
      src_s = SRC_BYP;
    end else begin
      src_s = SRC_NONE;
    end
  end

  assign pop_s  = (src_s == SRC_HEAD);
  assign push_s = rst && md_nz_s && (src_s != SRC_BYP);

  // Steer the granted source onto the regfile write port; x0 data is forced to zero
  always_comb begin
    dest_s  = 5'd0;
    wdata_s = 32'd0;
    case (src_s)
      SRC_PIPE: begin
        dest_s  = bus.pipe_rd;
        wdata_s = bus.pipe_data;
      end
      SRC_HEAD: begin
        dest_s  = rd_mem_r[head_r];
        wdata_s = data_mem_r[head_r];
      end
      SRC_BYP: begin
        dest_s  = bus.md_rd;
        wdata_s = bus.md_data;
      end
      default: begin
        dest_s  = 5'd0;
        wdata_s = 32'd0;
      end
    endcase
    if (dest_s == 5'd0) begin
      wdata_s = 32'd0;
    end else begin
      wdata_s = wdata_s;
    end
  end

  // One-hot OR of destinations held by occupied FIFO slots
  always_comb begin
    mask_s = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_r[i]) begin
        mask_s[rd_mem_r[i]] = 1'b1;
      end else begin
        mask_s = mask_s;
      end
    end
    mask_s[0] = 1'b0;
  end

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        rd_mem_r[i]   <= 5'd0;
        data_mem_r[i] <= 32'd0;
      end
      valid_r <= {DEPTH{1'b0}};
      head_r  <= {AW{1'b0}};
      tail_r  <= {AW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      if (pop_s) begin
        valid_r[head_r] <= 1'b0;
        head_r          <= head_r + AW'(1);
      end
      if (push_s) begin
        rd_mem_r[tail_r]   <= bus.md_rd;
        data_mem_r[tail_r] <= bus.md_data;
        valid_r[tail_r]    <= 1'b1;
        tail_r             <= tail_r + AW'(1);
      end
      if (push_s && !pop_s) begin
        count_r <= count_r + CW'(1);
      end else if (pop_s && !push_s) begin
        count_r <= count_r - CW'(1);
      end
    end
  end

  // Starvation counter: counts cycles a non-empty queue goes without a pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_r <= {SW{1'b0}};
    end else if (empty_s || pop_s) begin
      starve_r <= {SW{1'b0}};
    end else if (!stall_s) begin
      starve_r <= starve_r + SW'(1);
    end
  end

  assign bus.md_ready     = ready_s;
  assign bus.pipe_stall   = stall_s;
  assign bus.load_regfile = (src_s != SRC_NONE);
  assign bus.dest         = dest_s;
  assign bus.regfile_in   = wdata_s;
  assign bus.pending_mask = mask_s;
  assign bus.fifo_count   = count_r;
endmodule
